// File: rtl/fc_irq_bridge.sv
// fc_irq_bridge: remaps controller interrupt IDs onto one-hot core fast lines
// and turns the core's interrupt-taken pulse back into a controller ack.
module fc_irq_bridge #(
    parameter int N_FAST      = 15,
    parameter int ID_WIDTH    = 5,
    parameter int FIFO_IRQ_ID = 26,
    parameter int FIFO_LINE   = 10,
    parameter int CNT_W       = 8,
    localparam int LINE_W     = (N_FAST > 1) ? $clog2(N_FAST) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ctrl_irq_req_i,
    input  logic [ID_WIDTH-1:0] ctrl_irq_id_i,
    output logic                ctrl_irq_ack_o,
    output logic [ID_WIDTH-1:0] ctrl_irq_ack_id_o,
    output logic [N_FAST-1:0]   core_irq_fast_o,
    input  logic                core_irq_ack_i,
    input  logic [LINE_W-1:0]   core_irq_ack_id_i,
    output logic                busy_o,
    output logic [CNT_W-1:0]    drop_cnt_o,
    output logic [CNT_W-1:0]    spur_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_ACK} state_e;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [N_FAST-1:0]   fast_q, fast_d;
    logic                ack_q, ack_d;
    logic                ack_p_q;
    logic [ID_WIDTH-1:0] ack_id_q, ack_id_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [CNT_W-1:0]    spur_q, spur_d;
    logic                busy_q, busy_d;
    logic                hold;

    function automatic logic is_mappable(input logic [ID_WIDTH-1:0] id);
        return (32'(id) == 32'(FIFO_IRQ_ID)) || (32'(id) < 32'(N_FAST));
    endfunction

    function automatic logic [LINE_W-1:0] map_line(input logic [ID_WIDTH-1:0] id);
        if (32'(id) == 32'(FIFO_IRQ_ID)) return LINE_W'(FIFO_LINE);
        return LINE_W'(id);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Requests are ignored while our ack is visible and for one cycle after,
    // giving the controller time to drop the acknowledged request.
    assign hold = ack_q | ack_p_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        id_d     = id_q;
        fast_d   = fast_q;
        ack_d    = 1'b0;
        ack_id_d = ack_id_q;
        drop_d   = drop_q;
        spur_d   = spur_q;
        case (state_q)
            S_IDLE: begin
                fast_d = '0;
                if (ctrl_irq_req_i && !hold) begin
                    if (is_mappable(ctrl_irq_id_i)) begin
                        line_d  = map_line(ctrl_irq_id_i);
                        id_d    = ctrl_irq_id_i;
                        fast_d  = N_FAST'(1) << map_line(ctrl_irq_id_i);
                        state_d = S_ASSERT;
                    end else begin
                        ack_d    = 1'b1;
                        ack_id_d = ctrl_irq_id_i;
                        drop_d   = sat_inc(drop_q);
                    end
                end
            end
            S_ASSERT: begin
                // A matching core ack wins over withdrawal and retarget.
                if (core_irq_ack_i && core_irq_ack_id_i == line_q) begin
                    fast_d  = '0;
                    state_d = S_ACK;
                end else begin
                    if (core_irq_ack_i) spur_d = sat_inc(spur_q);
                    if (!ctrl_irq_req_i) begin
                        fast_d  = '0;
                        state_d = S_IDLE;
                    end else if (ctrl_irq_id_i != id_q) begin
                        if (is_mappable(ctrl_irq_id_i)) begin
                            line_d = map_line(ctrl_irq_id_i);
                            id_d   = ctrl_irq_id_i;
                            fast_d = N_FAST'(1) << map_line(ctrl_irq_id_i);
                        end else begin
                            fast_d   = '0;
                            ack_d    = 1'b1;
                            ack_id_d = ctrl_irq_id_i;
                            drop_d   = sat_inc(drop_q);
                            state_d  = S_IDLE;
                        end
                    end
                end
            end
            S_ACK: begin
                fast_d   = '0;
                ack_d    = 1'b1;
                ack_id_d = id_q;
                state_d  = S_IDLE;
            end
            default: begin
                fast_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            line_q   <= '0;
            id_q     <= '0;
            fast_q   <= '0;
            ack_q    <= 1'b0;
            ack_p_q  <= 1'b0;
            ack_id_q <= '0;
            drop_q   <= '0;
            spur_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            id_q     <= id_d;
            fast_q   <= fast_d;
            ack_q    <= ack_d;
            ack_p_q  <= ack_q;
            ack_id_q <= ack_id_d;
            drop_q   <= drop_d;
            spur_q   <= spur_d;
            busy_q   <= busy_d;
        end
    end

    assign ctrl_irq_ack_o    = ack_q;
    assign ctrl_irq_ack_id_o = ack_id_q;
    assign core_irq_fast_o   = fast_q;
    assign busy_o            = busy_q;
    assign drop_cnt_o        = drop_q;
    assign spur_cnt_o        = spur_q;

endmodule

// File: doc/fc_irq_bridge.md
FC_IRQ_BRIDGE -- requirements
Module: fc_irq_bridge

Interface
REQ-001 SHALL have parameter N_FAST, default 15, meaning the number of core fast-interrupt lines (legal range 1..32).
REQ-002 SHALL have parameter ID_WIDTH, default 5, meaning the width of the controller-side interrupt ID.
REQ-003 SHALL have parameter FIFO_IRQ_ID, default 26, meaning the controller ID of the SoC event FIFO interrupt.
REQ-004 SHALL have parameter FIFO_LINE, default 10, meaning the fast line that FIFO_IRQ_ID remaps to (must be < N_FAST).
REQ-005 SHALL have parameter CNT_W, default 8, meaning the width of the diagnostic counters.
REQ-006 SHALL derive LINE_W = max(1, clog2(N_FAST)).
REQ-007 SHALL provide the following ports, in this order:
- clk_i  in  1  clock; the block has one clock, and reset is synchronous and active-low
- rst_ni  in  1  synchronous active-low reset
- ctrl_irq_req_i  in  1  interrupt request level from the interrupt controller
- ctrl_irq_id_i  in  ID_WIDTH  ID of the requested interrupt
- ctrl_irq_ack_o  out  1  one-cycle acknowledge pulse to the controller
- ctrl_irq_ack_id_o  out  ID_WIDTH  controller ID being acknowledged
- core_irq_fast_o  out  N_FAST  one-hot fast-interrupt lines to the core
- core_irq_ack_i  in  1  core interrupt-taken pulse
- core_irq_ack_id_i  in  LINE_W  index of the line the core took
- busy_o  out  1  high whenever the FSM is not in IDLE
- drop_cnt_o  out  CNT_W  count of unmappable requests
- spur_cnt_o  out  CNT_W  count of mismatched core acks

Function
REQ-008 SHALL map a request ID as follows: ID == FIFO_IRQ_ID maps to FIFO_LINE; otherwise ID < N_FAST maps to line ID; any other ID is unmappable.
REQ-009 SHALL implement an FSM with states IDLE, ASSERT and ACK; all outputs SHALL be registered.
REQ-010 In IDLE with ctrl_irq_req_i high and a mappable ID, the block SHALL latch the line and the original ID, set core_irq_fast_o to the one-hot of that line on the next cycle, and go to ASSERT.
- Latency from request to line assertion is exactly 1 cycle.
REQ-011 In IDLE with ctrl_irq_req_i high and an unmappable ID, the block SHALL:
- pulse ctrl_irq_ack_o for one cycle with ctrl_irq_ack_id_o equal to that ID;
- increment drop_cnt_o;
- remain in IDLE and leave core_irq_fast_o at zero.
REQ-012 In IDLE, the block SHALL ignore a request during the cycle immediately after its own ack pulse, so the controller has one cycle to deassert the request.
REQ-013 In ASSERT, the block SHALL hold core_irq_fast_o as exactly one-hot, or all-zero, at all times.
REQ-014 In ASSERT with core_irq_ack_i high and core_irq_ack_id_i equal to the latched line, the block SHALL:
- go to ACK;
- clear core_irq_fast_o on the next cycle.
REQ-015 In ASSERT with core_irq_ack_i high and a non-matching core_irq_ack_id_i, the block SHALL increment spur_cnt_o and otherwise ignore the ack.
REQ-016 In ASSERT with ctrl_irq_req_i low and no matching ack, the block SHALL clear core_irq_fast_o, go to IDLE, and issue no ack (request withdrawn).
REQ-017 In ASSERT with ctrl_irq_req_i high and an ID different from the latched ID, the block SHALL retarget.
- A mappable new ID re-latches the ID and line and updates core_irq_fast_o the next cycle, staying in ASSERT.
- An unmappable new ID clears the lines, increments drop_cnt_o, acks that ID, and goes to IDLE.
REQ-018 When a matching core ack occurs in the same cycle as a withdrawal or retarget, the matching ack SHALL take priority.
REQ-019 In ACK, the block SHALL drive ctrl_irq_ack_o = 1 and ctrl_irq_ack_id_o = latched original ID for exactly one cycle, then return to IDLE.
- Example: line FIFO_LINE is acked as ID FIFO_IRQ_ID.
REQ-020 The block SHALL hold ctrl_irq_ack_o low in every cycle not described in REQ-011, REQ-017 and REQ-019.
REQ-021 drop_cnt_o and spur_cnt_o SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-022 The block SHALL drive busy_o = 1 in ASSERT and ACK.

Reset
REQ-023 While rst_ni is low at a clk_i rising edge, the block SHALL:
- set the FSM to IDLE;
- set core_irq_fast_o, ctrl_irq_ack_o, ctrl_irq_ack_id_o, busy_o, drop_cnt_o and spur_cnt_o to 0;
- clear the latched line and ID.
REQ-024 Reset asserted while in ASSERT or ACK SHALL abort without issuing a controller ack; the first post-reset cycle SHALL be IDLE.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- req=1, id=3 -> next cycle fast=0x0008, busy=1; core ack id 3 -> next cycle fast=0, then ctrl_ack=1 with ack_id=3 for one cycle, then IDLE.
- req=1, id=26 (defaults) -> fast=0x0400; core ack id 10 -> ctrl_ack_id=26.
- req=1, id=20 (unmappable) -> ctrl_ack=1 with ack_id=20 for one cycle, drop_cnt=1, fast stays 0.
- In ASSERT on id 3, core ack id 5 -> spur_cnt=1 and fast stays 0x0008; then ctrl id changes to 7 -> fast=0x0080, and a later ack acks ID 7.
- In ASSERT, ctrl req drops -> fast=0 next cycle with no ctrl_ack; separately, rst_ni=0 in the ACK cycle -> no ack pulse and all outputs 0.
- 300 unmappable requests with CNT_W=8 -> drop_cnt saturates at 255.
